// File: rtl/mem_arb_pkg.sv
// Shared types and port indices for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mux2.sv
// Two-input multiplexer; s=0 selects d0, s=1 selects d1.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an instruction
// fetch port (0, read-only) and a data port (1, read/write).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  arb_state_t    state, state_next;
  logic          grant, grant_next;
  logic          last;
  logic          we_lat;
  logic [CW-1:0] cnt;

  mux2 #(.W(AW)) u_addr_mux (
    .d0 (addr0),
    .d1 (addr1),
    .s  (grant),
    .y  (mem_addr)
  );

  mux2 #(.W(DW)) u_wdata_mux (
    .d0 ('0),
    .d1 (wdata1),
    .s  (grant),
    .y  (mem_wdata)
  );

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (req0 && req1)  grant_next = ~last;
        else if (req1)     grant_next = PORT_DATA;
        else if (req0)     grant_next = PORT_FETCH;
        if (req0 || req1)  state_next = BUSY;
      end
      BUSY:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= PORT_FETCH;
      last   <= PORT_DATA;
      we_lat <= 1'b0;
      cnt    <= '0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata  <= '0;
    end else begin
      state <= state_next;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant  <= grant_next;
            we_lat <= (grant_next == PORT_DATA) && we1;
            cnt    <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Writes leave the previously captured read data in place.
            if (!we_lat) rdata <= mem_rdata;
            last  <= grant;
            done0 <= (grant == PORT_FETCH);
            done1 <= (grant == PORT_DATA);
          end
        end
        default: ;
      endcase
    end
  end

  // cnt only counts down, so the load value marks the first BUSY cycle.
  assign mem_we = (state == BUSY) && we_lat && (cnt == CNT_LOAD);
  assign busy   = (state != IDLE);

endmodule
